dma_tcq_arbiter: RTL and testbench

- Shares one PCIe mover read-request queue (tcq request + completion-tag return) between NUM_CH independent DMA requesters, e.g. TX DMA and a secondary fetch engine.
- Grants requests round-robin and allocates physical PCIe tags from a shared pool.
- Records the owning channel and the requester's local tag, and routes each tag termination back to the owning channel.
- Sits between the per-channel dma_tx_pcie style request generators and the PCIe mover.

---
 rtl/dma_tcq_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dma_tcq_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tcq_arbiter.sv
// Round-robin arbiter that shares one PCIe mover read-request queue between
// NUM_CH DMA requesters, allocating physical tags and routing terminations back.
module dma_tcq_arbiter #(
  parameter int NUM_CH           = 2,
  parameter int RAM_ADDR_WIDTH   = 17,
  parameter int BUS_ADDR_WIDTH   = 32,
  parameter int DATA_BITS        = 3,
  parameter int REQUEST_LEN_BITS = 12,
  parameter int PCIE_TAG_BITS    = 5,
  parameter int CH_TAG_BITS      = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_CH-1:0]                                 ch_enable,
  input  logic [NUM_CH-1:0]                                 s_rq_valid,
  output logic [NUM_CH-1:0]                                 s_rq_ready,
  input  logic [NUM_CH*(RAM_ADDR_WIDTH-DATA_BITS)-1:0]      s_rq_laddr,
  input  logic [NUM_CH*(BUS_ADDR_WIDTH-DATA_BITS)-1:0]      s_rq_raddr,
  input  logic [NUM_CH*(REQUEST_LEN_BITS-DATA_BITS)-1:0]    s_rq_length,
  input  logic [NUM_CH*CH_TAG_BITS-1:0]                     s_rq_tag,
  output logic [NUM_CH-1:0]                                 s_cvalid,
  input  logic [NUM_CH-1:0]                                 s_cready,
  output logic [CH_TAG_BITS-1:0]                            s_ctag,
  output logic                                              m_tcq_valid,
  input  logic                                              m_tcq_ready,
  output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]               m_tcq_laddr,
  output logic [BUS_ADDR_WIDTH-DATA_BITS-1:0]               m_tcq_raddr,
  output logic [REQUEST_LEN_BITS-DATA_BITS-1:0]             m_tcq_length,
  output logic [PCIE_TAG_BITS-1:0]                          m_tcq_tag,
  input  logic                                              m_tcq_cvalid,
  output logic                                              m_tcq_cready,
  input  logic [PCIE_TAG_BITS-1:0]                          m_tcq_ctag,
  output logic [PCIE_TAG_BITS:0]                            stat_inflight,
  output logic                                              stat_bad_ctag,
  output logic                                              idle
);

  localparam int LW    = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int RW    = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int NW    = REQUEST_LEN_BITS - DATA_BITS;
  localparam int NTAGS = 1 << PCIE_TAG_BITS;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CHW-1:0]         CH_ONE   = CHW'(32'd1);
  localparam logic [CHW-1:0]         CH_LAST  = CHW'(NUM_CH - 1);
  localparam logic [PCIE_TAG_BITS:0] INFL_ONE = {{PCIE_TAG_BITS{1'b0}}, 1'b1};

  // Tag ownership table: allocation map plus {channel, local tag} per physical tag.
  logic [NTAGS-1:0]         alloc_r;
  logic [CHW-1:0]           own_ch_r  [NTAGS];
  logic [CH_TAG_BITS-1:0]   own_tag_r [NTAGS];

  logic [CHW-1:0]           rr_ptr_r;
  logic                     tcq_valid_r;
  logic [LW-1:0]            laddr_r;
  logic [RW-1:0]            raddr_r;
  logic [NW-1:0]            length_r;
  logic [PCIE_TAG_BITS-1:0] tag_r;
  logic [PCIE_TAG_BITS:0]   inflight_r;
  logic                     bad_ctag_r;

  logic [NUM_CH-1:0]        eligible_s;
  logic                     load_ok_s;
  logic                     win_found_s;
  logic [CHW-1:0]           win_idx_s;
  logic                     free_found_s;
  logic [PCIE_TAG_BITS-1:0] free_idx_s;
  logic                     grant_s;
  logic [NUM_CH-1:0]        rq_ready_s;
  logic                     c_alloc_s;
  logic [CHW-1:0]           c_owner_s;
  logic [NUM_CH-1:0]        cvalid_s;
  logic                     cready_s;
  logic                     free_s;
  logic                     bad_s;

  assign eligible_s = s_rq_valid & ch_enable;
  assign load_ok_s  = !tcq_valid_r || m_tcq_ready;

  // Round-robin search: first eligible channel at or after the pointer.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(rr_ptr_r) + k) % NUM_CH;
      if (!win_found_s && eligible_s[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = CHW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Lowest-index free tag, taken from the pre-edge map so a tag freed this cycle is not reused.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int t = 0; t < NTAGS; t++) begin
      if (!free_found_s && !alloc_r[t]) begin
        free_found_s = 1'b1;
        free_idx_s   = PCIE_TAG_BITS'(t);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  assign grant_s = !rst && load_ok_s && win_found_s && free_found_s;

  // One-hot accept toward the winning channel.
  always_comb begin
    rq_ready_s = '0;
    if (grant_s) begin
      rq_ready_s[win_idx_s] = 1'b1;
    end else begin
      rq_ready_s = '0;
    end
  end

  assign c_alloc_s = alloc_r[m_tcq_ctag];
  assign c_owner_s = own_ch_r[m_tcq_ctag];

  // Termination routing; unallocated tags are swallowed and flagged.
  always_comb begin
    cvalid_s = '0;
    cready_s = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      cvalid_s[i] = m_tcq_cvalid && c_alloc_s && (c_owner_s == CHW'(i));
    end
    if (c_alloc_s) begin
      cready_s = s_cready[c_owner_s];
    end else begin
      cready_s = 1'b1;
    end
  end

  assign free_s = m_tcq_cvalid && c_alloc_s && s_cready[c_owner_s];
  assign bad_s  = m_tcq_cvalid && !c_alloc_s;

  // Output request register: loads on grant, holds while the mover stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcq_valid_r <= 1'b0;
      laddr_r     <= '0;
      raddr_r     <= '0;
      length_r    <= '0;
      tag_r       <= '0;
      rr_ptr_r    <= '0;
    end else begin
      if (grant_s) begin
        tcq_valid_r <= 1'b1;
        laddr_r     <= s_rq_laddr[win_idx_s*LW +: LW];
        raddr_r     <= s_rq_raddr[win_idx_s*RW +: RW];
        length_r    <= s_rq_length[win_idx_s*NW +: NW];
        tag_r       <= free_idx_s;
        rr_ptr_r    <= (win_idx_s == CH_LAST) ? '0 : (win_idx_s + CH_ONE);
      end else if (m_tcq_ready) begin
        tcq_valid_r <= 1'b0;
      end
    end
  end

  // Tag allocation table, in-flight counter and sticky bad-tag flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_r    <= '0;
      inflight_r <= '0;
      bad_ctag_r <= 1'b0;
      for (int t = 0; t < NTAGS; t++) begin
        own_ch_r[t]  <= '0;
        own_tag_r[t] <= '0;
      end
    end else begin
      if (grant_s) begin
        alloc_r[free_idx_s]   <= 1'b1;
        own_ch_r[free_idx_s]  <= win_idx_s;
        own_tag_r[free_idx_s] <= s_rq_tag[win_idx_s*CH_TAG_BITS +: CH_TAG_BITS];
      end
      if (free_s) begin
        alloc_r[m_tcq_ctag] <= 1'b0;
      end
      case ({grant_s, free_s})
        2'b10:   inflight_r <= inflight_r + INFL_ONE;
        2'b01:   inflight_r <= inflight_r - INFL_ONE;
        default: inflight_r <= inflight_r;
      endcase
      if (bad_s) begin
        bad_ctag_r <= 1'b1;
      end
    end
  end

  assign s_rq_ready    = rq_ready_s;
  assign s_cvalid      = cvalid_s;
  assign s_ctag        = own_tag_r[m_tcq_ctag];
  assign m_tcq_cready  = cready_s;
  assign m_tcq_valid   = tcq_valid_r;
  assign m_tcq_laddr   = laddr_r;
  assign m_tcq_raddr   = raddr_r;
  assign m_tcq_length  = length_r;
  assign m_tcq_tag     = tag_r;
  assign stat_inflight = inflight_r;
  assign stat_bad_ctag = bad_ctag_r;
  assign idle          = (inflight_r == '0) && !tcq_valid_r;

endmodule

// File: tb/tb_dma_tcq_arbiter.sv
// Directed bench for dma_tcq_arbiter: expected mover requests are queued when
// stimulus is driven and compared when the mover accepts them.
module tb_dma_tcq_arbiter;

  localparam int NCH = 2;
  localparam int LW  = 14;
  localparam int RW  = 29;
  localparam int NW  = 9;
  localparam int PT  = 5;
  localparam int CT  = 4;

  logic                clk;
  logic                rst;
  logic [NCH-1:0]      ch_enable;
  logic [NCH-1:0]      s_rq_valid;
  logic [NCH-1:0]      s_rq_ready;
  logic [NCH*LW-1:0]   s_rq_laddr;
  logic [NCH*RW-1:0]   s_rq_raddr;
  logic [NCH*NW-1:0]   s_rq_length;
  logic [NCH*CT-1:0]   s_rq_tag;
  logic [NCH-1:0]      s_cvalid;
  logic [NCH-1:0]      s_cready;
  logic [CT-1:0]       s_ctag;
  logic                m_tcq_valid;
  logic                m_tcq_ready;
  logic [LW-1:0]       m_tcq_laddr;
  logic [RW-1:0]       m_tcq_raddr;
  logic [NW-1:0]       m_tcq_length;
  logic [PT-1:0]       m_tcq_tag;
  logic                m_tcq_cvalid;
  logic                m_tcq_cready;
  logic [PT-1:0]       m_tcq_ctag;
  logic [PT:0]         stat_inflight;
  logic                stat_bad_ctag;
  logic                idle;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] stall_exp;

  dma_tcq_arbiter dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable),
    .s_rq_valid(s_rq_valid), .s_rq_ready(s_rq_ready),
    .s_rq_laddr(s_rq_laddr), .s_rq_raddr(s_rq_raddr),
    .s_rq_length(s_rq_length), .s_rq_tag(s_rq_tag),
    .s_cvalid(s_cvalid), .s_cready(s_cready), .s_ctag(s_ctag),
    .m_tcq_valid(m_tcq_valid), .m_tcq_ready(m_tcq_ready),
    .m_tcq_laddr(m_tcq_laddr), .m_tcq_raddr(m_tcq_raddr),
    .m_tcq_length(m_tcq_length), .m_tcq_tag(m_tcq_tag),
    .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready),
    .m_tcq_ctag(m_tcq_ctag), .stat_inflight(stat_inflight),
    .stat_bad_ctag(stat_bad_ctag), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [LW-1:0] l, input logic [RW-1:0] r,
                                       input logic [NW-1:0] n, input logic [PT-1:0] t);
    return {7'd0, l, r, n, t};
  endfunction

  task automatic set_ch(input int ch, input logic [LW-1:0] l, input logic [RW-1:0] r,
                        input logic [NW-1:0] n, input logic [CT-1:0] t);
    s_rq_laddr[ch*LW +: LW]  = l;
    s_rq_raddr[ch*RW +: RW]  = r;
    s_rq_length[ch*NW +: NW] = n;
    s_rq_tag[ch*CT +: CT]    = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_rq_valid = '0;
    m_tcq_cvalid = 1'b0;
    sb_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // One round-robin grant step with both channels requesting.
  task automatic rr_step(input int k);
    #1;
    chk("rr_ready", {62'd0, s_rq_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
    if (k % 2 == 0) sb_q.push_back(pack(14'h20, 29'h2000, 9'd8, PT'(k)));
    else            sb_q.push_back(pack(14'h30, 29'h3000, 9'd4, PT'(k)));
    tick();
  endtask

  // Scoreboard consumer: every mover handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && m_tcq_valid && m_tcq_ready) begin
      chk("sb_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        chk("tcq_out", {7'd0, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag}, sb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; ch_enable = 2'b11; s_rq_valid = 2'b11; s_cready = 2'b00;
    s_rq_laddr = '0; s_rq_raddr = '0; s_rq_length = '0; s_rq_tag = '0;
    m_tcq_ready = 1'b1; m_tcq_cvalid = 1'b0; m_tcq_ctag = '0;
    tick(); tick();
    chk("rst_rq_ready", {62'd0, s_rq_ready}, 64'd0);
    chk("rst_valid", {63'd0, m_tcq_valid}, 64'd0);
    chk("rst_inflight", {58'd0, stat_inflight}, 64'd0);
    chk("rst_bad", {63'd0, stat_bad_ctag}, 64'd0);
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_cvalid", {62'd0, s_cvalid}, 64'd0);
    chk("rst_out", {7'd0, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag}, 64'd0);
    s_rq_valid = 2'b00;
    rst = 1'b0;

    // single channel request and its termination
    set_ch(0, 14'h10, 29'h1000, 9'd16, 4'd3);
    s_rq_valid = 2'b01;
    #1 chk("t1_ready", {62'd0, s_rq_ready}, 64'd1);
    sb_q.push_back(pack(14'h10, 29'h1000, 9'd16, 5'd0));
    tick();
    s_rq_valid = 2'b00;
    #1 chk("t1_valid", {63'd0, m_tcq_valid}, 64'd1);
    chk("t1_tag", {59'd0, m_tcq_tag}, 64'd0);
    chk("t1_inflight", {58'd0, stat_inflight}, 64'd1);
    tick();
    chk("t1_drain", {63'd0, m_tcq_valid}, 64'd0);
    m_tcq_cvalid = 1'b1; m_tcq_ctag = 5'd0; s_cready = 2'b01;
    #1 chk("t1_cvalid", {62'd0, s_cvalid}, 64'd1);
    chk("t1_ctag", {60'd0, s_ctag}, 64'd3);
    chk("t1_cready", {63'd0, m_tcq_cready}, 64'd1);
    tick();
    m_tcq_cvalid = 1'b0;
    #1 chk("t1_inflight0", {58'd0, stat_inflight}, 64'd0);
    chk("t1_idle", {63'd0, idle}, 64'd1);

    // round robin across both channels, then fill the whole pool
    do_reset();
    set_ch(0, 14'h20, 29'h2000, 9'd8, 4'd2);
    set_ch(1, 14'h30, 29'h3000, 9'd4, 4'd7);
    s_rq_valid = 2'b11;
    for (int k = 0; k < 8; k++) rr_step(k);
    #1 chk("rr_inflight8", {58'd0, stat_inflight}, 64'd8);
    for (int k = 8; k < 32; k++) rr_step(k);
    #1 chk("full_inflight", {58'd0, stat_inflight}, 64'd32);
    chk("full_ready", {62'd0, s_rq_ready}, 64'd0);
    tick();
    chk("full_ready2", {62'd0, s_rq_ready}, 64'd0);
    chk("full_drain", {63'd0, m_tcq_valid}, 64'd0);

    // free tag 5 (owned by ch1): not reusable in the free cycle, granted the next
    m_tcq_cvalid = 1'b1; m_tcq_ctag = 5'd5; s_cready = 2'b11;
    #1 chk("t5_cvalid", {62'd0, s_cvalid}, 64'd2);
    chk("t5_ctag", {60'd0, s_ctag}, 64'd7);
    chk("t5_no_reuse", {62'd0, s_rq_ready}, 64'd0);
    tick();
    m_tcq_cvalid = 1'b0;
    #1 chk("t5_ready", {62'd0, s_rq_ready}, 64'd1);
    sb_q.push_back(pack(14'h20, 29'h2000, 9'd8, 5'd5));
    tick();
    s_rq_valid = 2'b00;
    #1 chk("t5_tag", {59'd0, m_tcq_tag}, 64'd5);
    chk("t5_inflight", {58'd0, stat_inflight}, 64'd32);

    // free tags 0 and 1 to make room for the stall test
    m_tcq_cvalid = 1'b1; m_tcq_ctag = 5'd0;
    tick();
    m_tcq_ctag = 5'd1;
    tick();
    m_tcq_cvalid = 1'b0;
    #1 chk("free2_inflight", {58'd0, stat_inflight}, 64'd30);

    // mover stall: output must hold, nothing more is accepted
    m_tcq_ready = 1'b0;
    set_ch(1, 14'h55, 29'h5500, 9'd5, 4'd9);
    s_rq_valid = 2'b11;
    #1 chk("st_ready", {62'd0, s_rq_ready}, 64'd2);
    stall_exp = pack(14'h55, 29'h5500, 9'd5, 5'd0);
    sb_q.push_back(stall_exp);
    tick();
    set_ch(0, 14'h77, 29'h7700, 9'd7, 4'd1);
    set_ch(1, 14'h66, 29'h6600, 9'd6, 4'd10);
    for (int c = 0; c < 4; c++) begin
      #1 chk("st_valid", {63'd0, m_tcq_valid}, 64'd1);
      chk("st_noready", {62'd0, s_rq_ready}, 64'd0);
      chk("st_hold", {7'd0, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag}, stall_exp);
      chk("st_inflight", {58'd0, stat_inflight}, 64'd31);
      tick();
    end
    s_rq_valid = 2'b00;
    m_tcq_ready = 1'b1;
    tick();
    chk("st_drain", {63'd0, m_tcq_valid}, 64'd0);

    // ch1 termination back-pressured for three cycles
    m_tcq_cvalid = 1'b1; m_tcq_ctag = 5'd3; s_cready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1 chk("c1_cready", {63'd0, m_tcq_cready}, 64'd0);
      chk("c1_cvalid", {62'd0, s_cvalid}, 64'd2);
      chk("c1_ctag", {60'd0, s_ctag}, 64'd7);
      tick();
      chk("c1_inflight", {58'd0, stat_inflight}, 64'd31);
    end
    m_tcq_cvalid = 1'b0; s_cready = 2'b11;

    // reset with a request sitting in the output register
    s_rq_valid = 2'b11;
    #1 chk("mt_ready", {62'd0, s_rq_ready}, 64'd1);
    sb_q.push_back(pack(14'h77, 29'h7700, 9'd7, 5'd1));
    tick();
    s_rq_valid = 2'b00;
    #1 chk("mt_valid", {63'd0, m_tcq_valid}, 64'd1);
    do_reset();
    #1 chk("rs_inflight", {58'd0, stat_inflight}, 64'd0);
    chk("rs_valid", {63'd0, m_tcq_valid}, 64'd0);
    chk("rs_idle", {63'd0, idle}, 64'd1);

    // termination for tag 9, owned before the reset and now unallocated
    m_tcq_cvalid = 1'b1; m_tcq_ctag = 5'd9; s_cready = 2'b00;
    #1 chk("bad_cready", {63'd0, m_tcq_cready}, 64'd1);
    chk("bad_cvalid", {62'd0, s_cvalid}, 64'd0);
    chk("bad_pre", {63'd0, stat_bad_ctag}, 64'd0);
    tick();
    m_tcq_cvalid = 1'b0;
    #1 chk("bad_set", {63'd0, stat_bad_ctag}, 64'd1);
    tick(); tick(); tick();
    chk("bad_sticky", {63'd0, stat_bad_ctag}, 64'd1);
    chk("bad_inflight", {58'd0, stat_inflight}, 64'd0);
    do_reset();
    #1 chk("bad_clr", {63'd0, stat_bad_ctag}, 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
